// File: rtl/float_window_accumulator_pkg.sv
// Shared types and constants for the float window accumulator:
// controller states, legal window sizes and their IEEE-754 single encodings.
package float_window_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [5:0] SIZE_4  = 6'd4;
  localparam logic [5:0] SIZE_9  = 6'd9;
  localparam logic [5:0] SIZE_16 = 6'd16;
  localparam logic [5:0] SIZE_25 = 6'd25;
  localparam logic [5:0] SIZE_36 = 6'd36;

  localparam logic [31:0] DIV_4  = 32'h4080_0000;
  localparam logic [31:0] DIV_9  = 32'h4110_0000;
  localparam logic [31:0] DIV_16 = 32'h4180_0000;
  localparam logic [31:0] DIV_25 = 32'h41C8_0000;
  localparam logic [31:0] DIV_36 = 32'h4210_0000;

  // Anything outside the legal set falls back to the largest window.
  function automatic logic [5:0] legal_size(input logic [5:0] w);
    case (w)
      SIZE_4, SIZE_9, SIZE_16, SIZE_25, SIZE_36: legal_size = w;
      default: legal_size = SIZE_36;
    endcase
  endfunction

  function automatic logic [31:0] size_encoding(input logic [5:0] w);
    case (w)
      SIZE_4:  size_encoding = DIV_4;
      SIZE_9:  size_encoding = DIV_9;
      SIZE_16: size_encoding = DIV_16;
      SIZE_25: size_encoding = DIV_25;
      default: size_encoding = DIV_36;
    endcase
  endfunction

endpackage

// File: rtl/float_window_accumulator_float_adder.sv
// Combinational IEEE-754 adder with round-to-nearest-even; denormals are
// handled, infinities/NaNs on an input are passed straight through.
module float_adder #(
  parameter int DATA_WIDTH = 32,
  parameter int E = 8,
  parameter int M = 23
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] sum
);

  localparam int W = M + 4;

  logic          sa, sb, a_big, sign_l, sticky, round_up;
  logic [E-1:0]  ea, eb, ea_eff, eb_eff, exp_l, exp_s, diff, exp_field;
  logic [M-1:0]  fa, fb;
  logic [M:0]    man_l, man_s;
  logic [W-1:0]  small_ext, aligned, norm;
  logic [W:0]    raw;
  logic [E+1:0]  exp_r;
  logic [M+1:0]  mant_r;

  always_comb begin
    sa = a[DATA_WIDTH-1];
    sb = b[DATA_WIDTH-1];
    ea = a[DATA_WIDTH-2 -: E];
    eb = b[DATA_WIDTH-2 -: E];
    fa = a[M-1:0];
    fb = b[M-1:0];
    ea_eff = (ea == '0) ? E'(1) : ea;
    eb_eff = (eb == '0) ? E'(1) : eb;

    a_big  = {ea, fa} >= {eb, fb};
    sign_l = a_big ? sa : sb;
    exp_l  = a_big ? ea_eff : eb_eff;
    exp_s  = a_big ? eb_eff : ea_eff;
    man_l  = a_big ? {|ea, fa} : {|eb, fb};
    man_s  = a_big ? {|eb, fb} : {|ea, fa};
    diff   = exp_l - exp_s;

    // Align the smaller operand, folding shifted-out bits into a sticky bit.
    small_ext = {man_s, 3'b000};
    if (diff >= E'(W)) begin
      aligned = '0;
      sticky  = |man_s;
    end else begin
      aligned = small_ext >> diff;
      sticky  = |(small_ext & ~({W{1'b1}} << diff));
    end
    aligned[0] = aligned[0] | sticky;

    if (sa == sb) raw = {1'b0, man_l, 3'b000} + {1'b0, aligned};
    else          raw = {1'b0, man_l, 3'b000} - {1'b0, aligned};

    exp_r = {2'b00, exp_l};
    if (raw[W]) begin
      norm    = raw[W:1];
      norm[0] = norm[0] | raw[0];
      exp_r   = exp_r + (E+2)'(1);
    end else begin
      norm = raw[W-1:0];
    end
    for (int i = 0; i < W; i++) begin
      if (!norm[W-1] && exp_r > (E+2)'(1)) begin
        norm  = norm << 1;
        exp_r = exp_r - (E+2)'(1);
      end
    end

    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r   = {1'b0, norm[W-1:3]} + (M+2)'(round_up);
    if (mant_r[M+1]) begin
      mant_r = mant_r >> 1;
      exp_r  = exp_r + (E+2)'(1);
    end
    exp_field = mant_r[M] ? exp_r[E-1:0] : '0;

    if (raw == '0)
      sum = '0;
    else if (exp_r >= {2'b00, {E{1'b1}}})
      sum = {sign_l, {E{1'b1}}, {M{1'b0}}};
    else
      sum = {sign_l, exp_field, mant_r[M-1:0]};

    if (&ea)      sum = a;
    else if (&eb) sum = b;
  end

endmodule

// File: rtl/float_window_accumulator.sv
// Accumulates a window of 4/9/16/25/36 floats and presents the sum plus the
// float window size for a downstream divider. Define ACC_DENORM_FLUSH_EN to flush denormal inputs to +0.
module float_window_accumulator
  import float_window_accumulator_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int E = 8,
  parameter int M = 23
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [5:0]            win_size,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_sum,
  output logic [DATA_WIDTH-1:0] out_div
);

  state_t                state;
  logic [5:0]            count, size;
  logic [DATA_WIDTH-1:0] acc, operand, add_result, next_acc;
  logic                  accept, last;

`ifdef ACC_DENORM_FLUSH_EN
  assign operand = (in_data[DATA_WIDTH-2 -: E] == '0) ? '0 : in_data;
`else
  assign operand = in_data;
`endif

  float_adder #(.DATA_WIDTH(DATA_WIDTH), .E(E), .M(M)) u_adder (
    .a   (acc),
    .b   (operand),
    .sum (add_result)
  );

  // The first element bypasses the adder so stale accumulator contents never leak in.
  assign next_acc = (count == '0) ? operand : add_result;
  assign accept   = in_valid && in_ready;
  assign last     = (count + 6'd1) == size;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      count     <= '0;
      size      <= '0;
      acc       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_div   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            size     <= legal_size(win_size);
            count    <= '0;
            in_ready <= 1'b1;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc   <= next_acc;
            count <= count + 6'd1;
            if (last) begin
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_sum   <= next_acc;
              out_div   <= DATA_WIDTH'(size_encoding(size));
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_window_accumulator.sv
// Scoreboard bench for float_window_accumulator: expected sum/divisor pairs
// are queued as each window is driven and checked when the result handshakes.
module tb_float_window_accumulator;

  logic        clk = 1'b0;
  logic        reset_n, start, in_valid, out_ready;
  logic [5:0]  win_size;
  logic [31:0] in_data;
  logic        in_ready, out_valid;
  logic [31:0] out_sum, out_div;

  int          tests = 0;
  int          failed = 0;
  logic [63:0] sb_q[$];
  logic [31:0] elem_q[$];

  always #5 clk = ~clk;

  float_window_accumulator #(.DATA_WIDTH(32), .E(8), .M(23)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .win_size  (win_size),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_div   (out_div)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Exact single-precision encoding of a small signed integer.
  function automatic logic [31:0] int_to_float(input int n);
    int          mag, p;
    logic [31:0] r;
    if (n == 0) return 32'h0;
    mag = (n < 0) ? -n : n;
    p = 0;
    for (int i = 0; i < 31; i++) if ((mag >> i) != 0) p = i;
    r[31]    = (n < 0);
    r[30:23] = 8'(127 + p);
    r[22:0]  = 23'((mag - (1 << p)) << (23 - p));
    return r;
  endfunction

  function automatic int window_len(input logic [5:0] ws);
    if (ws == 6'd4 || ws == 6'd9 || ws == 6'd16 || ws == 6'd25 || ws == 6'd36) return int'(ws);
    return 36;
  endfunction

  // Results are checked on the falling edge where the handshake is about to complete.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_out_valid", {31'b0, out_valid}, 32'd0);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        checkOutput("out_sum", out_sum, e[63:32]);
        checkOutput("out_div", out_div, e[31:0]);
      end
    end
  end

  task automatic applyStimulus(input logic [5:0] ws, input logic [31:0] exp_sum, input bit mid_restart);
    int idx = 0;
    int guard = 0;
    sb_q.push_back({exp_sum, int_to_float(window_len(ws))});
    start = 1'b1;
    win_size = ws;
    @(posedge clk); #1;
    start = 1'b0;
    while (idx < elem_q.size() && guard < 200) begin
      in_valid = 1'b1;
      in_data  = elem_q[idx];
      if (mid_restart && idx == 1) begin
        start    = 1'b1;
        win_size = 6'd4;
      end
      @(negedge clk);
      if (in_ready) idx++;
      @(posedge clk); #1;
      start = 1'b0;
      guard++;
    end
    in_valid = 1'b0;
    if (idx < elem_q.size()) checkOutput("drive_timeout", 32'(idx), 32'(elem_q.size()));
    elem_q.delete();
  endtask

  task automatic waitDrain(input int max_cycles);
    int n = 0;
    while (sb_q.size() != 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checkOutput("drain_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int sum;
    int v;
    logic [5:0] sizes[6] = '{6'd4, 6'd9, 6'd16, 6'd25, 6'd36, 6'd0};

    reset_n = 1'b0; start = 1'b0; win_size = 6'd0; in_valid = 1'b0;
    in_data = 32'h0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_out_sum", out_sum, 32'h0);
    checkOutput("rst_out_div", out_div, 32'h0);
    reset_n = 1'b1;

    // in_valid while idle must be ignored
    in_valid = 1'b1; in_data = 32'h42C8_0000;
    repeat (3) begin
      @(negedge clk);
      checkOutput("idle_in_ready", {31'b0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;

    // 1+2+3+4 with one-cycle latency
    elem_q = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
    applyStimulus(6'd4, 32'h4120_0000, 1'b0);
    @(negedge clk);
    checkOutput("latency_out_valid", {31'b0, out_valid}, 32'd1);
    waitDrain(10);

    // nine ones held while downstream stalls
    out_ready = 1'b0;
    repeat (9) elem_q.push_back(32'h3F80_0000);
    applyStimulus(6'd9, 32'h4110_0000, 1'b0);
    repeat (5) begin
      @(negedge clk);
      checkOutput("hold_out_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("hold_out_sum", out_sum, 32'h4110_0000);
      checkOutput("hold_out_div", out_div, 32'h4110_0000);
    end
    out_ready = 1'b1;
    waitDrain(10);
    @(negedge clk);
    checkOutput("post_hold_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("post_hold_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;

    // illegal size becomes 36
    repeat (36) elem_q.push_back(32'h3F00_0000);
    applyStimulus(6'd7, 32'h4190_0000, 1'b0);
    waitDrain(10);

    // start during accumulation must not relatch the size
    for (int k = 1; k <= 9; k++) elem_q.push_back(int_to_float(k));
    applyStimulus(6'd9, int_to_float(45), 1'b1);
    waitDrain(10);

    // mixed-sign integer windows across every size
    foreach (sizes[s]) begin
      sum = 0;
      for (int k = 0; k < window_len(sizes[s]); k++) begin
        v = int'($urandom_range(0, 40)) - 20;
        sum += v;
        elem_q.push_back(int_to_float(v));
      end
      applyStimulus(sizes[s], int_to_float(sum), 1'b0);
      waitDrain(10);
    end

    // smallest denormals
    repeat (4) elem_q.push_back(32'h0000_0001);
`ifdef ACC_DENORM_FLUSH_EN
    applyStimulus(6'd4, 32'h0000_0000, 1'b0);
`else
    applyStimulus(6'd4, 32'h0000_0004, 1'b0);
`endif
    waitDrain(10);

    elem_q = '{32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
    applyStimulus(6'd4, 32'h4040_0000, 1'b0);
    waitDrain(10);

    // reset part-way through a size-16 window
    elem_q = '{32'h3F80_0000, 32'h3F80_0000};
    applyStimulus(6'd16, 32'h0, 1'b0);
    void'(sb_q.pop_back());
    #2 reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("mid_rst_out_sum", out_sum, 32'h0);
    checkOutput("mid_rst_out_div", out_div, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
    end
    @(posedge clk); #1;
    for (int k = 5; k <= 8; k++) elem_q.push_back(int_to_float(k));
    applyStimulus(6'd4, int_to_float(26), 1'b0);
    waitDrain(10);

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
